// File: rtl/tqvp_byte_uart_host.sv
// UART-driven bus initiator for TinyQV byte peripherals: decodes serial
// write/read commands into peripheral register accesses and returns read data.
module tqvp_byte_uart_host #(
  parameter int CLKS_PER_BIT = 556
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  output logic [3:0] per_address_o,
  output logic       per_data_write_o,
  output logic [7:0] per_data_out_o,
  input  logic [7:0] per_data_in_i,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
  typedef enum logic [2:0] {
    P_IDLE, P_WAIT_DATA, P_WRITE, P_READ_SAMPLE, P_READ_SEND
  } pState_e;

  logic [1:0]       rxSync_q;
  logic             rxPrev_q;
  rxState_e         rxState_q, rxState_d;
  logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]       rxBit_q, rxBit_d;
  logic [7:0]       rxShift_q, rxShift_d;
  logic             holdFull_q, holdFull_d;
  logic [7:0]       holdData_q, holdData_d;
  pState_e          pState_q, pState_d;
  logic [3:0]       addrLatch_q, addrLatch_d;
  logic [3:0]       perAddr_q, perAddr_d;
  logic [7:0]       perData_q, perData_d;
  logic [7:0]       txHold_q, txHold_d;
  logic             txActive_q, txActive_d;
  logic [9:0]       txShift_q, txShift_d;
  logic [CNT_W-1:0] txCnt_q, txCnt_d;
  logic [3:0]       txBit_q, txBit_d;

  logic       rxS;
  logic       rxValid;
  logic       rxFrameErr;
  logic       byteAvail;
  logic [7:0] byteIn;
  logic       consume;
  logic       txStart;

  assign rxS = rxSync_q[1];

  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    rxBit_d    = rxBit_q;
    rxShift_d  = rxShift_q;
    rxValid    = 1'b0;
    rxFrameErr = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxPrev_q && !rxS) begin
          rxState_d = RX_START;
          rxCnt_d   = '0;
        end
      end
      RX_START: begin
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxS ? RX_IDLE : RX_DATA;
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = {rxS, rxShift_q[7:1]};
          rxBit_d   = rxBit_q + 3'd1;
          if (rxBit_q == 3'd7) rxState_d = RX_STOP;
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rxCnt_q == BIT_LAST) begin
          rxState_d  = RX_IDLE;
          rxValid    = rxS;
          rxFrameErr = !rxS;
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // A freshly received byte bypasses the hold register when the parser can take it at once.
  assign byteAvail = holdFull_q | rxValid;
  assign byteIn    = holdFull_q ? holdData_q : rxShift_q;

  always_comb begin
    pState_d    = pState_q;
    addrLatch_d = addrLatch_q;
    perAddr_d   = perAddr_q;
    perData_d   = perData_q;
    txHold_d    = txHold_q;
    consume     = 1'b0;
    txStart     = 1'b0;
    case (pState_q)
      P_IDLE: begin
        if (byteAvail) begin
          consume = 1'b1;
          if (byteIn[6:4] == 3'b000) begin
            if (byteIn[7]) begin
              addrLatch_d = byteIn[3:0];
              pState_d    = P_WAIT_DATA;
            end else begin
              perAddr_d = byteIn[3:0];
              pState_d  = P_READ_SAMPLE;
            end
          end
        end
      end
      P_WAIT_DATA: begin
        // A corrupted frame abandons the half-received write command.
        if (rxFrameErr) begin
          pState_d = P_IDLE;
        end else if (byteAvail) begin
          consume   = 1'b1;
          perAddr_d = addrLatch_q;
          perData_d = byteIn;
          pState_d  = P_WRITE;
        end
      end
      P_WRITE: pState_d = P_IDLE;
      P_READ_SAMPLE: begin
        txHold_d = per_data_in_i;
        pState_d = P_READ_SEND;
      end
      P_READ_SEND: begin
        if (!txActive_q) begin
          txStart  = 1'b1;
          pState_d = P_IDLE;
        end
      end
      default: pState_d = P_IDLE;
    endcase
  end

  always_comb begin
    holdFull_d = holdFull_q;
    holdData_d = holdData_q;
    if (holdFull_q) begin
      if (consume) begin
        holdFull_d = rxValid;
        holdData_d = rxShift_q;
      end
    end else if (rxValid && !consume) begin
      holdFull_d = 1'b1;
      holdData_d = rxShift_q;
    end
  end

  always_comb begin
    txActive_d = txActive_q;
    txShift_d  = txShift_q;
    txCnt_d    = txCnt_q;
    txBit_d    = txBit_q;
    if (txStart) begin
      txActive_d = 1'b1;
      txShift_d  = {1'b1, txHold_q, 1'b0};
      txCnt_d    = '0;
      txBit_d    = '0;
    end else if (txActive_q) begin
      if (txCnt_q == BIT_LAST) begin
        txCnt_d   = '0;
        txShift_d = {1'b1, txShift_q[9:1]};
        txBit_d   = txBit_q + 4'd1;
        if (txBit_q == 4'd9) txActive_d = 1'b0;
      end else begin
        txCnt_d = txCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxSync_q    <= 2'b11;
      rxPrev_q    <= 1'b1;
      rxState_q   <= RX_IDLE;
      rxCnt_q     <= '0;
      rxBit_q     <= '0;
      rxShift_q   <= '0;
      holdFull_q  <= 1'b0;
      holdData_q  <= '0;
      pState_q    <= P_IDLE;
      addrLatch_q <= '0;
      perAddr_q   <= '0;
      perData_q   <= '0;
      txHold_q    <= '0;
      txActive_q  <= 1'b0;
      txShift_q   <= '1;
      txCnt_q     <= '0;
      txBit_q     <= '0;
    end else begin
      rxSync_q    <= {rxSync_q[0], uart_rx_i};
      rxPrev_q    <= rxS;
      rxState_q   <= rxState_d;
      rxCnt_q     <= rxCnt_d;
      rxBit_q     <= rxBit_d;
      rxShift_q   <= rxShift_d;
      holdFull_q  <= holdFull_d;
      holdData_q  <= holdData_d;
      pState_q    <= pState_d;
      addrLatch_q <= addrLatch_d;
      perAddr_q   <= perAddr_d;
      perData_q   <= perData_d;
      txHold_q    <= txHold_d;
      txActive_q  <= txActive_d;
      txShift_q   <= txShift_d;
      txCnt_q     <= txCnt_d;
      txBit_q     <= txBit_d;
    end
  end

  assign uart_tx_o        = txActive_q ? txShift_q[0] : 1'b1;
  assign per_address_o    = perAddr_q;
  assign per_data_out_o   = perData_q;
  assign per_data_write_o = (pState_q == P_WRITE);
  assign busy_o           = (pState_q != P_IDLE) | txActive_q | holdFull_q;

endmodule

// File: tb/tb_tqvp_byte_uart_host.sv
// Scoreboard bench for tqvp_byte_uart_host: serial commands in, expected
// peripheral writes and serial responses queued and matched as they appear.
module tb_tqvp_byte_uart_host;

  localparam int CLKS = 16;
  localparam int HALF = CLKS / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uartRx = 1'b1;
  logic       uartTx;
  logic [3:0] perAddress;
  logic       perDataWrite;
  logic [7:0] perDataOut;
  logic [7:0] perDataIn;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int txStartCycle = 0;
  logic txInFrame = 1'b0;
  logic resetSeen = 1'b0;

  logic [7:0]  expTx[$];
  logic [11:0] expWr[$];
  logic [7:0]  expMem [16];

  logic [7:0] periphRegs [16];
  logic       periphInit = 1'b0;

  tqvp_byte_uart_host #(.CLKS_PER_BIT(CLKS)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .uart_rx_i        (uartRx),
    .uart_tx_o        (uartTx),
    .per_address_o    (perAddress),
    .per_data_write_o (perDataWrite),
    .per_data_out_o   (perDataOut),
    .per_data_in_i    (perDataIn),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  always @(negedge rst_n) resetSeen = 1'b1;

  // Peripheral model: 16 byte registers, combinational read, strobed write.
  always @(posedge clk) begin
    if (!periphInit) begin
      for (int i = 0; i < 16; i++) periphRegs[i] <= {4'(i), ~4'(i)};
      periphInit <= 1'b1;
    end else if (perDataWrite) begin
      periphRegs[perAddress] <= perDataOut;
    end
  end

  assign perDataIn = periphRegs[perAddress];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    uartRx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    uartRx = stopBit;
    repeat (CLKS) @(negedge clk);
    uartRx = 1'b1;
  endtask

  task automatic sendWrite(input logic [3:0] a, input logic [7:0] d);
    expWr.push_back({a, d});
    expMem[a] = d;
    applyStimulus({4'h8, a}, 1'b1);
    applyStimulus(d, 1'b1);
  endtask

  task automatic sendRead(input logic [3:0] a);
    expTx.push_back(expMem[a]);
    applyStimulus({4'h0, a}, 1'b1);
  endtask

  task automatic idleBits(input int n);
    uartRx = 1'b1;
    repeat (n * CLKS) @(negedge clk);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (expTx.size() == 0 && expWr.size() == 0 && !busy && !txInFrame) break;
    end
    checkOutput("drainTx", 32'(expTx.size()), 32'd0);
    checkOutput("drainWr", 32'(expWr.size()), 32'd0);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    repeat (2 * CLKS) @(negedge clk);
  endtask

  // Serial response monitor; frames cut short by reset are dropped unchecked.
  initial begin : txMon
    logic [7:0] rxd;
    logic [7:0] e;
    logic       startBit;
    logic       stopBit;
    forever begin
      @(negedge uartTx);
      if (!rst_n) continue;
      txInFrame    = 1'b1;
      resetSeen    = 1'b0;
      txStartCycle = cycleCnt;
      repeat (HALF) @(posedge clk);
      #1 startBit = uartTx;
      for (int b = 0; b < 8; b++) begin
        repeat (CLKS) @(posedge clk);
        #1 rxd[b] = uartTx;
      end
      repeat (CLKS) @(posedge clk);
      #1 stopBit = uartTx;
      if (resetSeen) begin
        if (expTx.size() != 0) void'(expTx.pop_front());
      end else begin
        checkOutput("txExpected", 32'(expTx.size() != 0), 32'd1);
        if (expTx.size() != 0) begin
          e = expTx.pop_front();
          checkOutput("txData", 32'(rxd), 32'(e));
        end
        checkOutput("txStartBit", 32'(startBit), 32'd0);
        checkOutput("txStopBit", 32'(stopBit), 32'd1);
      end
      txInFrame = 1'b0;
    end
  end

  initial begin : wrMon
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && perDataWrite) begin
        checkOutput("wrExpected", 32'(expWr.size() != 0), 32'd1);
        if (expWr.size() != 0) begin
          e = expWr.pop_front();
          checkOutput("wrAddr", 32'(perAddress), 32'(e[11:8]));
          checkOutput("wrData", 32'(perDataOut), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 16; i++) expMem[i] = {4'(i), ~4'(i)};

    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstTx", 32'(uartTx), 32'd1);
    checkOutput("rstWrite", 32'(perDataWrite), 32'd0);
    checkOutput("rstAddr", 32'(perAddress), 32'd0);
    checkOutput("rstDataOut", 32'(perDataOut), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    idleBits(2);

    $display("[TB] write 0x85 0xA5");
    sendWrite(4'h5, 8'hA5);
    waitDrain();
    checkOutput("wrHoldAddr", 32'(perAddress), 32'h5);
    checkOutput("wrHoldData", 32'(perDataOut), 32'hA5);

    $display("[TB] read address 3");
    sendRead(4'h3);
    waitDrain();
    checkOutput("rdAddr", 32'(perAddress), 32'h3);
    checkOutput("rdKeepData", 32'(perDataOut), 32'hA5);

    $display("[TB] read back written address 5");
    sendRead(4'h5);
    waitDrain();

    $display("[TB] framing error then read 2");
    applyStimulus(8'h85, 1'b0);
    idleBits(2);
    sendRead(4'h2);
    waitDrain();

    $display("[TB] reserved command 0x40 then read 1");
    applyStimulus(8'h40, 1'b1);
    sendRead(4'h1);
    waitDrain();

    $display("[TB] short glitch then read 0");
    uartRx = 1'b0;
    repeat (5) @(negedge clk);
    idleBits(2);
    sendRead(4'h0);
    waitDrain();

    $display("[TB] back-to-back reads 0..3");
    for (int a = 0; a < 4; a++) sendRead(4'(a));
    waitDrain();
    checkOutput("b2bAddr", 32'(perAddress), 32'h3);

    $display("[TB] reset during response data bit 4");
    sendRead(4'h3);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txInFrame && cycleCnt >= txStartCycle + 5 * CLKS + HALF) break;
    end
    checkOutput("midTxInFrame", 32'(txInFrame), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midTxLineHigh", 32'(uartTx), 32'd1);
    checkOutput("midTxBusy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30 * CLKS) @(negedge clk);
    checkOutput("postRstQueue", 32'(expTx.size()), 32'd0);
    checkOutput("postRstTx", 32'(uartTx), 32'd1);
    checkOutput("postRstInFrame", 32'(txInFrame), 32'd0);
    checkOutput("postRstAddr", 32'(perAddress), 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule
